// File: rtl/seq_4_bit_divider_pkg.sv
// Shared definitions for the sequential 4-bit divider.
//   WIDTH       operand / quotient / remainder width
//   ITER_COUNT  number of restoring-division steps (one quotient bit each)
//   CNT_W       width of the iteration counter
//   DIV0_QUOT   quotient reported for a zero divisor
//   state_e     controller states
//   neg_if      conditional two's-complement negation
package seq_4_bit_divider_pkg;

  localparam int WIDTH      = 4;
  localparam int ITER_COUNT = 4;
  localparam int CNT_W      = $clog2(ITER_COUNT);

  localparam logic [WIDTH-1:0] DIV0_QUOT = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_FIX
  } state_e;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v,
                                              input logic             n);
    return n ? -v : v;
  endfunction

endpackage

// File: rtl/seq_4_bit_divider_four_bit_adder.sv
// Plain 4-bit ripple-style adder with carry in/out.
//   a_i, b_i  addends
//   cin_i     carry in
//   sum_o     4-bit sum
//   cout_o    carry out
module four_bit_adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};

endmodule

// File: rtl/seq_4_bit_divider.sv
// Sequential restoring divider, unsigned or two's-complement 4-bit operands.
//   CLOCK_50  clock, rising edge
//   RESET     synchronous active-high reset
//   SW        [8:5] dividend A, [4:1] divisor B, [0] mode (1 = signed)
//   START     level request, accepted only in IDLE
//   LEDG      quotient
//   LEDR      [3:0] remainder, [4] divide-by-zero, [5] signed overflow
//   BUSY      operation in progress
//   DONE      one-cycle pulse when LEDG/LEDR take a new result
module seq_4_bit_divider
  import seq_4_bit_divider_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [8:0] SW,
  input  logic       START,
  output logic [3:0] LEDG,
  output logic [5:0] LEDR,
  output logic       BUSY,
  output logic       DONE
);

  state_e             state_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               mode_q;
  logic [WIDTH-1:0]   dvd_q;     // dividend magnitude, consumed MSB first
  logic [WIDTH-1:0]   dvs_q;     // divisor magnitude
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_quo_q, neg_rem_q;
  logic [3:0]         ledg_q;
  logic [5:0]         ledr_q;
  logic               done_q;

  logic [WIDTH:0]     shift_rem;
  logic [WIDTH-1:0]   diff_lo;
  logic               carry_lo;
  logic               trial_ge;
  logic [WIDTH-1:0]   rem_d;
  logic               ovf;

  // Partial remainder can reach 2*14+1 in unsigned mode, so the trial
  // subtraction runs on 5 bits: the low 4 through the adder, the divisor's
  // zero-extended MSB handled here.
  assign shift_rem = {rem_q, dvd_q[WIDTH-1]};

  four_bit_adder u_sub (
    .a_i    (shift_rem[WIDTH-1:0]),
    .b_i    (~dvs_q),
    .cin_i  (1'b1),
    .sum_o  (diff_lo),
    .cout_o (carry_lo)
  );

  // No borrow out of bit 4: inverted divisor MSB is 1, so carry = a[4] | c4.
  // When non-negative the difference is below the divisor, so bit 4 is zero.
  assign trial_ge = shift_rem[WIDTH] | carry_lo;
  assign rem_d    = trial_ge ? diff_lo : shift_rem[WIDTH-1:0];

  assign ovf = mode_q && (a_q == 4'b1000) && (b_q == 4'b1111);

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ledg_q    <= '0;
      ledr_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (START) begin
            a_q     <= SW[8:5];
            b_q     <= SW[4:1];
            mode_q  <= SW[0];
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          // -8 negates to 4'b1000, read as unsigned 8 from here on
          dvd_q     <= neg_if(a_q, mode_q & a_q[WIDTH-1]);
          dvs_q     <= neg_if(b_q, mode_q & b_q[WIDTH-1]);
          neg_quo_q <= mode_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_rem_q <= mode_q & a_q[WIDTH-1];
          rem_q     <= '0;
          quo_q     <= '0;
          cnt_q     <= '0;
          state_q   <= (b_q == '0) ? S_FIX : S_ITER;
        end
        S_ITER: begin
          rem_q <= rem_d;
          quo_q <= {quo_q[WIDTH-2:0], trial_ge};
          dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(ITER_COUNT - 1)) state_q <= S_FIX;
        end
        S_FIX: begin
          if (b_q == '0) begin
            ledg_q <= DIV0_QUOT;
            ledr_q <= {2'b01, a_q};
          end else begin
            // -8 / -1 yields magnitude 8 = 4'b1000 unnegated, which is
            // already the reported overflow quotient; only the flag is added.
            ledg_q <= neg_if(quo_q, neg_quo_q);
            ledr_q <= {ovf, 1'b0, neg_if(rem_q, neg_rem_q)};
          end
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign LEDG = ledg_q;
  assign LEDR = ledr_q;
  assign DONE = done_q;
  assign BUSY = (state_q != S_IDLE);

endmodule

// File: tb/tb_seq_4_bit_divider.sv
module tb_seq_4_bit_divider;

  logic       CLOCK_50 = 1'b0;
  logic       RESET    = 1'b1;
  logic [8:0] SW       = '0;
  logic       START    = 1'b0;
  logic [3:0] LEDG;
  logic [5:0] LEDR;
  logic       BUSY;
  logic       DONE;

  int total = 0;
  int bad   = 0;

  seq_4_bit_divider dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .SW       (SW),
    .START    (START),
    .LEDG     (LEDG),
    .LEDR     (LEDR),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference result from plain integer division (truncates toward zero,
  // remainder carries the dividend's sign).
  task automatic ref_div(input logic [3:0] a, input logic [3:0] b, input logic m,
                         output logic [3:0] q, output logic [5:0] r);
    int ai, bi, qi, ri;
    if (b == 4'd0) begin
      q = 4'hF;
      r = {2'b01, a};
    end else if (m && a == 4'b1000 && b == 4'b1111) begin
      q = 4'b1000;
      r = 6'b100000;
    end else begin
      if (m) begin
        ai = int'($signed(a));
        bi = int'($signed(b));
      end else begin
        ai = int'(a);
        bi = int'(b);
      end
      qi = ai / bi;
      ri = ai % bi;
      q  = qi[3:0];
      r  = {2'b00, ri[3:0]};
    end
  endtask

  // Model: an accepted request completes after a fixed number of edges.
  bit         chk_en = 1'b0;
  bit         m_busy = 1'b0;
  bit         m_done = 1'b0;
  logic [3:0] m_ledg = '0;
  logic [5:0] m_ledr = '0;
  int         m_left = 0;
  logic [3:0] m_a, m_b;
  logic       m_mode;

  always @(posedge CLOCK_50) begin
    if (RESET) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_ledg = '0;
      m_ledr = '0;
      m_left = 0;
      chk_en = 1'b1;
    end else begin
      m_done = 1'b0;
      if (m_left == 0) begin
        if (START) begin
          m_a    = SW[8:5];
          m_b    = SW[4:1];
          m_mode = SW[0];
          m_left = (SW[4:1] == 4'd0) ? 2 : 6;
          m_busy = 1'b1;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          ref_div(m_a, m_b, m_mode, m_ledg, m_ledr);
        end
      end
    end
  end

  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      check("busy", 12'(BUSY), 12'(m_busy));
      check("done", 12'(DONE), 12'(m_done));
      check("ledg", 12'(LEDG), 12'(m_ledg));
      check("ledr", 12'(LEDR), 12'(m_ledr));
    end
  end

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic m,
                        output int lat);
    @(negedge CLOCK_50);
    SW    = {a, b, m};
    START = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    START = 1'b0;
    lat = 0;
    do begin
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      lat++;
    end while (!DONE && lat < 20);
    check("op_done_seen", 12'(DONE), 12'd1);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [3:0] cq;
    logic [5:0] cr;

    // Pin the reference itself with hand-computed values.
    ref_div(4'b1001, 4'b0010, 1'b1, cq, cr);
    check("model_signed", {2'b00, cq, cr}, {2'b00, 4'b1101, 6'b001111});
    ref_div(4'd13, 4'd3, 1'b0, cq, cr);
    check("model_unsigned", {2'b00, cq, cr}, {2'b00, 4'd4, 6'b000001});

    RESET = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("rst_ledg", 12'(LEDG), 12'd0);
    check("rst_ledr", 12'(LEDR), 12'd0);
    check("rst_busy", 12'(BUSY), 12'd0);
    check("rst_done", 12'(DONE), 12'd0);
    RESET = 1'b0;

    run_op(4'd13, 4'd3, 1'b0, lat);
    check("u_lat", 12'(lat), 12'd6);
    check("u_ledg", 12'(LEDG), 12'd4);
    check("u_ledr", 12'(LEDR), 12'b000001);

    run_op(4'b1001, 4'b0010, 1'b1, lat);
    check("s_lat", 12'(lat), 12'd6);
    check("s_ledg", 12'(LEDG), 12'b1101);
    check("s_ledr", 12'(LEDR), 12'b001111);

    run_op(4'd9, 4'd0, 1'b0, lat);
    check("div0_lat", 12'(lat), 12'd2);
    check("div0_ledg", 12'(LEDG), 12'hF);
    check("div0_ledr", 12'(LEDR), 12'b011001);

    run_op(4'b1000, 4'b1111, 1'b1, lat);
    check("ovf_ledg", 12'(LEDG), 12'b1000);
    check("ovf_ledr", 12'(LEDR), 12'b100000);

    // START re-asserted with new operands while iterating
    @(negedge CLOCK_50);
    SW = {4'd14, 4'd4, 1'b0};
    START = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    START = 1'b0;
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    START = 1'b1;
    SW = {4'd3, 4'd1, 1'b0};
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    START = 1'b0;
    pulses = 0;
    cq = '0;
    cr = '0;
    repeat (10) begin
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      if (DONE) begin
        pulses++;
        cq = LEDG;
        cr = LEDR;
      end
    end
    check("busy_start_pulses", 12'(pulses), 12'd1);
    check("busy_start_ledg", 12'(cq), 12'd3);
    check("busy_start_ledr", 12'(cr), 12'd2);

    // Reset while iterating
    @(negedge CLOCK_50);
    SW = {4'd7, 4'd2, 1'b0};
    START = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    START = 1'b0;
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    RESET = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    RESET = 1'b0;
    check("abort_busy", 12'(BUSY), 12'd0);
    check("abort_ledg", 12'(LEDG), 12'd0);
    check("abort_ledr", 12'(LEDR), 12'd0);
    check("abort_done", 12'(DONE), 12'd0);
    pulses = 0;
    repeat (8) begin
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      if (DONE) pulses++;
    end
    check("abort_no_done", 12'(pulses), 12'd0);
    run_op(4'd7, 4'd2, 1'b0, lat);
    check("after_abort_ledg", 12'(LEDG), 12'd3);
    check("after_abort_ledr", 12'(LEDR), 12'd1);

    // START held high: back-to-back operations, one per 7 edges
    @(negedge CLOCK_50);
    SW = {4'd5, 4'd2, 1'b0};
    START = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      if (DONE) pulses++;
    end
    START = 1'b0;
    check("held_start_pulses", 12'(pulses), 12'd2);
    repeat (8) @(negedge CLOCK_50);

    // Randomized traffic, checked every cycle against the model
    repeat (600) begin
      @(negedge CLOCK_50);
      SW = 9'($urandom);
      if ($urandom_range(0, 7) == 0) SW[4:1] = 4'd0;
      if ($urandom_range(0, 9) == 0) SW = {4'b1000, 4'b1111, 1'b1};
      START = ($urandom_range(0, 2) == 0);
      RESET = ($urandom_range(0, 59) == 0);
    end
    @(negedge CLOCK_50);
    RESET = 1'b0;
    START = 1'b0;
    repeat (10) @(negedge CLOCK_50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
